// File: rtl/common.sv
// common: shared front-panel button FSM states and timing constants
package common;
  typedef enum logic [2:0] {IDLE, PRESSED, SHORT_OUT, LONG, PAUSE_OUT} btn_state_t;
  localparam int BTN_DEBOUNCE_28M = 280000;
endpackage

// File: rtl/debounce.sv
// debounce: 2-FF synchroniser plus stable-time filter for an active-low raw button
module debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk28,
  input  logic rst,
  input  logic in_n,
  output logic out
);
  localparam int W = $clog2(CYCLES + 1);
  logic [1:0] sync_ff;
  logic [W-1:0] db_cnt;
  logic sync;
  assign sync = ~sync_ff[1];
  always_ff @(posedge clk28)
    if (rst) begin
      sync_ff <= 2'b11;
      db_cnt <= '0;
      out <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], in_n};
      if (sync == out) db_cnt <= '0;
      else if (db_cnt == W'(CYCLES - 1)) begin
        out <= sync;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
endmodule

// File: rtl/magic_buttons.sv
// magic_buttons: debounced short/long press to frame-aligned magic/pause levels; MAGIC_KBD_EN enables keyboard hot-key strobes
module magic_buttons import common::*; #(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_28M,
  parameter int LONG_FRAMES = 50,
  parameter int HOLD_FRAMES = 2
) (
  input  logic clk28,
  input  logic rst,
  input  logic btn_n,
  input  logic n_int,
  input  logic kbd_magic,
  input  logic kbd_pause,
  output logic magic_button,
  output logic pause_button,
  output logic btn_pressed
);
`ifdef MAGIC_KBD_EN
  localparam bit KBD_EN = 1'b1;
`else
  localparam bit KBD_EN = 1'b0;
`endif
  localparam int ARM_CYCLES = DEBOUNCE_CYCLES + 2;
  localparam int FW = $clog2(LONG_FRAMES + 1);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int AW = $clog2(ARM_CYCLES + 1);
  btn_state_t state, nxt;
  logic [FW-1:0] frame_cnt;
  logic [HW-1:0] hold_cnt;
  logic [AW-1:0] arm_cnt;
  logic n_int_q, btn_q, armed, frame_tick, rise, long_hit, hold_hit, kbd_m, kbd_p, arm_done;
  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk28(clk28),
    .rst(rst),
    .in_n(btn_n),
    .out(btn_pressed)
  );
  assign frame_tick = n_int_q & ~n_int;
  assign rise = armed & btn_pressed & ~btn_q;
  assign kbd_m = KBD_EN & kbd_magic;
  assign kbd_p = KBD_EN & kbd_pause;
  assign long_hit = frame_tick && frame_cnt == FW'(LONG_FRAMES - 1);
  assign hold_hit = frame_tick && hold_cnt == HW'(HOLD_FRAMES - 1);
  assign arm_done = arm_cnt == AW'(ARM_CYCLES);
  always_comb
    nxt = state == IDLE    ? (rise ? PRESSED : kbd_m ? SHORT_OUT : kbd_p ? PAUSE_OUT : IDLE) :
          state == PRESSED ? (!btn_pressed ? SHORT_OUT : long_hit ? LONG : PRESSED) :
          state == LONG    ? (btn_pressed ? LONG : IDLE) :
          (state == SHORT_OUT || state == PAUSE_OUT) ? (hold_hit ? IDLE : state) : IDLE;
  always_ff @(posedge clk28)
    if (rst) begin
      state <= IDLE;
      frame_cnt <= '0;
      hold_cnt <= '0;
      arm_cnt <= '0;
      n_int_q <= 1'b1;
      btn_q <= 1'b0;
      armed <= 1'b0;
      magic_button <= 1'b0;
      pause_button <= 1'b0;
    end else begin
      state <= nxt;
      n_int_q <= n_int;
      btn_q <= btn_pressed;
      arm_cnt <= arm_done ? arm_cnt : arm_cnt + 1'b1;
      armed <= armed | (btn_q & ~btn_pressed) | (arm_done & ~btn_pressed);
      frame_cnt <= nxt != state ? '0 :
                   (state == PRESSED && frame_tick && frame_cnt != FW'(LONG_FRAMES)) ? frame_cnt + 1'b1 : frame_cnt;
      hold_cnt <= nxt != state ? '0 :
                  (state inside {SHORT_OUT, PAUSE_OUT} && frame_tick && hold_cnt != HW'(HOLD_FRAMES)) ? hold_cnt + 1'b1 : hold_cnt;
      magic_button <= nxt == SHORT_OUT;
      pause_button <= nxt == LONG || nxt == PAUSE_OUT;
    end
endmodule

// File: tb/tb_magic_buttons.sv
// tb_magic_buttons: directed checks of debounce, short/long press, keyboard strobes and reset
module tb_magic_buttons;
`ifdef MAGIC_KBD_EN
  localparam bit KBD = 1'b1;
`else
  localparam bit KBD = 1'b0;
`endif
  logic clk28 = 1'b0, rst, btn_n, n_int, kbd_magic, kbd_pause;
  logic magic_button, pause_button, btn_pressed;
  int n_checks = 0, n_fail = 0, cyc = 0, ph = 1, t0, t1;
  int m_rise, m_fall, p_rise, p_fall, b_rise, m_rises;
  logic m_prev = 1'b0, p_prev = 1'b0, b_prev = 1'b0, m_any, p_any, b_any;
  magic_buttons #(.DEBOUNCE_CYCLES(4), .LONG_FRAMES(3), .HOLD_FRAMES(2)) dut (
    .clk28(clk28),
    .rst(rst),
    .btn_n(btn_n),
    .n_int(n_int),
    .kbd_magic(kbd_magic),
    .kbd_pause(kbd_pause),
    .magic_button(magic_button),
    .pause_button(pause_button),
    .btn_pressed(btn_pressed)
  );
  always #5 clk28 = ~clk28;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic clr();
    m_rise = -1; m_fall = -1; p_rise = -1; p_fall = -1; b_rise = -1; m_rises = 0;
    m_any = 1'b0; p_any = 1'b0; b_any = 1'b0;
  endtask
  task automatic start(input int p);
    ph = p;
    n_int = 1'b1;
    t0 = cyc;
    clr();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk28);
      #1;
      cyc++;
      ph = (ph == 99) ? 0 : ph + 1;
      n_int = (ph != 0);
      if (magic_button && !m_prev) begin m_rise = cyc; m_rises++; end
      if (!magic_button && m_prev) m_fall = cyc;
      if (pause_button && !p_prev) p_rise = cyc;
      if (!pause_button && p_prev) p_fall = cyc;
      if (btn_pressed && !b_prev) b_rise = cyc;
      m_prev = magic_button; p_prev = pause_button; b_prev = btn_pressed;
      m_any |= magic_button; p_any |= pause_button; b_any |= btn_pressed;
    end
  endtask
  initial begin
    rst = 1'b1; btn_n = 1'b1; n_int = 1'b1; kbd_magic = 1'b0; kbd_pause = 1'b0;
    clr();
    run(3);
    check("reset_magic", int'(magic_button), 0);
    check("reset_pause", int'(pause_button), 0);
    check("reset_btn", int'(btn_pressed), 0);
    rst = 1'b0;
    run(10);
    start(50);
    for (int i = 0; i < 10; i++) begin
      btn_n = i[0];
      run(2);
    end
    btn_n = 1'b1;
    run(20);
    check("bounce_btn", int'(b_any), 0);
    check("bounce_magic", int'(m_any), 0);
    check("bounce_pause", int'(p_any), 0);
    start(50);
    btn_n = 1'b0;
    run(150);
    btn_n = 1'b1;
    run(250);
    check("short_btn_rise", b_rise - t0, 6);
    check("short_magic_rise", m_rise - t0, 157);
    check("short_magic_fall", m_fall - t0, 351);
    check("short_pause", int'(p_any), 0);
    start(50);
    btn_n = 1'b0;
    run(400);
    btn_n = 1'b1;
    run(20);
    check("long_pause_rise", p_rise - t0, 251);
    check("long_pause_fall", p_fall - t0, 407);
    check("long_magic", int'(m_any), 0);
    start(50);
    btn_n = 1'b0;
    run(244);
    btn_n = 1'b1;
    run(300);
    check("tie_magic_rise", m_rise - t0, 251);
    check("tie_magic_fall", m_fall - t0, 451);
    check("tie_pause", int'(p_any), 0);
    start(50);
    btn_n = 1'b0;
    run(6);
    kbd_magic = 1'b1;
    run(1);
    kbd_magic = 1'b0;
    run(23);
    btn_n = 1'b1;
    run(250);
    check("prio_magic_rise", m_rise - t0, 37);
    start(50);
    kbd_pause = 1'b1;
    run(1);
    kbd_pause = 1'b0;
    run(199);
    check("kbd_pause_rise", p_rise, KBD ? t0 + 1 : -1);
    check("kbd_pause_fall", p_fall, KBD ? t0 + 151 : -1);
    check("kbd_pause_magic", int'(m_any), 0);
    start(50);
    kbd_magic = 1'b1;
    run(1);
    kbd_magic = 1'b0;
    run(99);
    kbd_magic = 1'b1;
    run(1);
    kbd_magic = 1'b0;
    run(300);
    check("kbd_magic_rise", m_rise, KBD ? t0 + 1 : -1);
    check("kbd_magic_fall", m_fall, KBD ? t0 + 151 : -1);
    check("kbd_magic_count", m_rises, KBD ? 1 : 0);
    check("kbd_magic_pause", int'(p_any), 0);
    start(50);
    btn_n = 1'b0;
    run(260);
    check("rst_long_pause_rise", p_rise - t0, 251);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check("rst_magic", int'(magic_button), 0);
    check("rst_pause", int'(pause_button), 0);
    check("rst_btn", int'(btn_pressed), 0);
    clr();
    run(400);
    check("held_pause", int'(p_any), 0);
    check("held_magic", int'(m_any), 0);
    btn_n = 1'b1;
    run(20);
    clr();
    btn_n = 1'b0;
    run(30);
    btn_n = 1'b1;
    t1 = cyc;
    run(250);
    check("repress_magic_rise", m_rise - t1, 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
